// File: rtl/wfunc_loader.sv
// wfunc_loader: APB master that soft-resets window_func, streams the window
// coefficients into its memory, arms it and polls until the window is ready.
module wfunc_loader #(
  parameter int unsigned FFT_SIZE  = 8192,
  parameter int unsigned APB_AW    = $clog2(FFT_SIZE-1)+3,
  parameter int unsigned POLL_GAP  = 4,
  parameter int unsigned MAX_POLLS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  input  logic              coef_tvalid,
  output logic              coef_tready,
  input  logic [31:0]       coef_tdata,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [APB_AW-1:0] paddr,
  output logic [31:0]       pwdata,
  input  logic [31:0]       prdata
);

  localparam int unsigned CW = (FFT_SIZE > 1) ? $clog2(FFT_SIZE) : 1;
  localparam int unsigned PW = $clog2(MAX_POLLS+1);
  localparam int unsigned GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [APB_AW-1:0] CTRL_ADDR = APB_AW'(FFT_SIZE*4);
  localparam logic [APB_AW-1:0] STAT_ADDR = APB_AW'((FFT_SIZE+1)*4);

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_LOAD, S_ARM, S_POLL, S_GAP, S_FIN
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              last_q, last_d;
  logic [PW-1:0]     poll_q, poll_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [APB_AW-1:0] paddr_q, paddr_d;
  logic [31:0]       pwdata_q, pwdata_d;
  logic              tready_q, tready_d, busy_q, busy_d;
  logic              done_q, done_d, error_q, error_d;
  logic              setup_q, access_q;
  logic              unused_prdata;

  assign setup_q       = psel_q & ~penable_q;
  assign access_q      = psel_q & penable_q;
  // Only the window state field of the status word is of interest.
  assign unused_prdata = ^{prdata[31:10], prdata[7:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b0;
      poll_q    <= '0;
      gap_q     <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      tready_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      poll_q    <= poll_d;
      gap_q     <= gap_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      tready_q  <= tready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  // Next state and next registered outputs; a setup cycle always becomes an access cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    poll_d    = poll_q;
    gap_d     = gap_q;
    psel_d    = 1'b0;
    penable_d = 1'b0;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RST;
          psel_d   = 1'b1;
          pwrite_d = 1'b1;
          paddr_d  = CTRL_ADDR;
          pwdata_d = 32'h1;
        end
      end
      S_RST: begin
        if (setup_q) begin
          psel_d    = 1'b1;
          penable_d = 1'b1;
        end else begin
          state_d = S_LOAD;
          cnt_d   = '0;
          last_d  = 1'b0;
        end
      end
      S_LOAD: begin
        if (setup_q) begin
          psel_d    = 1'b1;
          penable_d = 1'b1;
        end else if (coef_tvalid && tready_q) begin
          psel_d   = 1'b1;
          pwrite_d = 1'b1;
          paddr_d  = APB_AW'({cnt_q, 2'b00});
          pwdata_d = coef_tdata;
          cnt_d    = cnt_q + CW'(1);
          last_d   = (cnt_q == CW'(FFT_SIZE-1));
        end else if (access_q && last_q) begin
          state_d  = S_ARM;
          psel_d   = 1'b1;
          pwrite_d = 1'b1;
          paddr_d  = CTRL_ADDR;
          pwdata_d = 32'h100;
        end
      end
      S_ARM: begin
        if (setup_q) begin
          psel_d    = 1'b1;
          penable_d = 1'b1;
        end else begin
          state_d  = S_POLL;
          psel_d   = 1'b1;
          pwrite_d = 1'b0;
          paddr_d  = STAT_ADDR;
          pwdata_d = '0;
          poll_d   = '0;
        end
      end
      S_POLL: begin
        if (setup_q) begin
          psel_d    = 1'b1;
          penable_d = 1'b1;
        end else if (prdata[9:8] == 2'b01 || prdata[9:8] == 2'b10) begin
          state_d = S_FIN;
          done_d  = 1'b1;
        end else if (poll_q == PW'(MAX_POLLS-1)) begin
          state_d = S_FIN;
          error_d = 1'b1;
        end else begin
          poll_d = poll_q + PW'(1);
          if (POLL_GAP == 0) begin
            psel_d = 1'b1;
          end else begin
            state_d = S_GAP;
            gap_d   = '0;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GW'(POLL_GAP-1)) begin
          state_d = S_POLL;
          psel_d  = 1'b1;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_IDLE || state_d == S_FIN) begin
      pwrite_d = 1'b0;
      paddr_d  = '0;
      pwdata_d = '0;
    end
    // Accept a word only when the next cycle is free to be its setup cycle.
    tready_d = (state_d == S_LOAD) && !(psel_d && !penable_d) && !last_d;
    busy_d   = (state_d != S_IDLE);
  end

  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign coef_tready = tready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;

endmodule

// File: tb/tb_wfunc_loader.sv
// tb_wfunc_loader: directed scenarios with randomized data, source stalls and
// slave status, checked against a transaction-level model of the load sequence.
module tb_wfunc_loader;

  localparam int unsigned N       = 8;
  localparam int unsigned AW      = $clog2(N-1)+3;
  localparam int unsigned GAP     = 4;
  localparam int unsigned MAXP    = 16;
  localparam int unsigned SRC_LEN = N + 2;
  localparam logic [AW-1:0] CTRL  = AW'(N*4);
  localparam logic [AW-1:0] STAT  = AW'((N+1)*4);

  typedef struct packed {
    logic          w;
    logic [AW-1:0] a;
    logic [31:0]   d;
  } txn_t;

  logic          clk = 1'b0;
  logic          rst_n, start, busy, done, error;
  logic          coef_tvalid, coef_tready;
  logic [31:0]   coef_tdata;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [31:0]   pwdata, prdata;

  always #5 clk = ~clk;

  wfunc_loader #(.FFT_SIZE(N), .APB_AW(AW), .POLL_GAP(GAP), .MAX_POLLS(MAXP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .error(error),
    .coef_tvalid(coef_tvalid), .coef_tready(coef_tready), .coef_tdata(coef_tdata),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata)
  );

  int n_cmp = 0;
  int n_mis = 0;
  int run_no = 0;
  int src_mode = 0;
  int fail_reads = 0;
  logic [31:0] src_data [SRC_LEN];
  logic [1:0]  st_fail [MAXP];
  logic [1:0]  st_ok = 2'b01;
  logic [1:0]  rd_status;
  logic [21:0] rd_hi = '0;
  logic [7:0]  rd_lo = '0;

  // Source / slave side state, owned by the source process.
  int cyc = 0;
  int src_idx = 0;
  int rd_idx = 0;
  bit hs = 1'b0;

  // Slave status: fail_reads unready answers, then a ready one.
  always_comb begin
    rd_status = st_ok;
    if (rd_idx < fail_reads) rd_status = st_fail[rd_idx % MAXP];
  end
  assign prdata = {rd_hi, rd_status, rd_lo};

  initial begin
    int seen = 0;
    int ph = 0;
    bit rd_now;
    bit v;
    coef_tvalid = 1'b0;
    coef_tdata  = '0;
    forever begin
      @(posedge clk);
      cyc++;
      hs     = coef_tvalid && coef_tready;
      rd_now = psel && penable && !pwrite;
      #1;
      if (seen != run_no) begin
        seen = run_no; src_idx = 0; rd_idx = 0; ph = 0;
      end else begin
        if (hs) src_idx++;
        if (rd_now) rd_idx++;
      end
      ph++;
      case (src_mode)
        0:       v = 1'b1;
        1:       v = (ph % 3 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      coef_tvalid = (src_idx < SRC_LEN) && v;
      coef_tdata  = (src_idx < SRC_LEN) ? src_data[src_idx] : 32'h0;
    end
  end

  // Bus monitor: completed transfers, pulses and protocol observations.
  txn_t txq[$];
  int   rd_cyc[$];
  int   n_done, n_err, done_cyc, err_cyc, busy_rise, busy_fall;
  int   tready_viol, starve_viol;
  logic busy_prev;
  int   mseen = 0;

  always @(negedge clk) begin
    if (mseen != run_no) begin
      mseen = run_no;
      txq.delete(); rd_cyc.delete();
      n_done = 0; n_err = 0; done_cyc = -1; err_cyc = -1;
      busy_rise = -1; busy_fall = -1; busy_prev = 1'b0;
      tready_viol = 0; starve_viol = 0;
    end
    if (rst_n) begin
      if (psel && penable) begin
        txq.push_back('{w: pwrite, a: paddr, d: pwdata});
        if (!pwrite) rd_cyc.push_back(cyc);
      end
      if (psel && !penable && coef_tready) tready_viol++;
      if (psel && !penable && pwrite && paddr < CTRL && !hs) starve_viol++;
      if (done) begin n_done++; done_cyc = cyc; end
      if (error) begin n_err++; err_cyc = cyc; end
      if (busy && !busy_prev && busy_rise < 0) busy_rise = cyc;
      if (!busy && busy_prev) busy_fall = cyc;
      busy_prev = busy;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic setup_run(input int mode, input int fails, input bit nominal);
    for (int k = 0; k < SRC_LEN; k++)
      src_data[k] = nominal ? 32'(k) * 32'h0001_0001 : $urandom;
    for (int k = 0; k < MAXP; k++)
      st_fail[k] = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
    st_ok      = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
    rd_hi      = 22'($urandom);
    rd_lo      = 8'($urandom);
    src_mode   = mode;
    fail_reads = fails;
    run_no++;
    repeat (2) @(negedge clk);
  endtask

  task automatic kick(output int s0);
    @(negedge clk);
    start = 1'b1;
    s0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int s0, input int dup_at);
    int t = 0;
    while (n_done + n_err == 0 && t < 600) begin
      @(negedge clk);
      t++;
      start = (dup_at > 0 && cyc == s0 + dup_at);
    end
    start = 1'b0;
    check("end_within_budget", 64'(t < 600), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  // Expected transfer list and timing from the load/arm/poll rules.
  task automatic check_run(input int s0, input int fails, input int mode);
    txn_t exp_q[$];
    txn_t o;
    int   reads = (fails < int'(MAXP)) ? fails + 1 : int'(MAXP);
    int   end_cyc, last_rd, gv;
    exp_q.push_back('{w: 1'b1, a: CTRL, d: 32'h1});
    for (int k = 0; k < int'(N); k++)
      exp_q.push_back('{w: 1'b1, a: AW'(k*4), d: src_data[k]});
    exp_q.push_back('{w: 1'b1, a: CTRL, d: 32'h100});
    for (int r = 0; r < reads; r++)
      exp_q.push_back('{w: 1'b0, a: STAT, d: 32'h0});
    check("txn_count", 64'(txq.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < txq.size(); i++) begin
      o = txq[i];
      if (!o.w) o.d = '0;
      check($sformatf("txn[%0d]", i), 64'(o), 64'(exp_q[i]));
    end
    check("done_pulses", 64'(n_done), (fails < int'(MAXP)) ? 64'd1 : 64'd0);
    check("error_pulses", 64'(n_err), (fails < int'(MAXP)) ? 64'd0 : 64'd1);
    check("tready_in_setup", 64'(tready_viol), 64'd0);
    check("starved_xfer", 64'(starve_viol), 64'd0);
    check("words_consumed", 64'(src_idx), 64'(N));
    gv = 0;
    for (int i = 1; i < rd_cyc.size(); i++)
      if (rd_cyc[i] - rd_cyc[i-1] != int'(2 + GAP)) gv++;
    check("poll_spacing", 64'(gv), 64'd0);
    end_cyc = (fails < int'(MAXP)) ? done_cyc : err_cyc;
    last_rd = (rd_cyc.size() > 0) ? rd_cyc[rd_cyc.size()-1] : -100;
    check("end_after_last_read", 64'(end_cyc), 64'(last_rd + 1));
    check("busy_rise", 64'(busy_rise), 64'(s0 + 1));
    check("busy_fall", 64'(busy_fall), 64'(end_cyc + 1));
    if (mode == 0)
      check("end_cycle", 64'(end_cyc), 64'(s0 + 2*int'(N) + 8 + (reads-1)*int'(2 + GAP)));
    check("idle_outputs", 64'({psel, penable, pwrite, paddr, pwdata, coef_tready, busy, done, error}), 64'd0);
  endtask

  initial begin
    int s0;
    int f;
    int t;
    rst_n = 1'b0;
    start = 1'b0;
    for (int k = 0; k < SRC_LEN; k++) src_data[k] = '0;
    for (int k = 0; k < MAXP; k++) st_fail[k] = 2'b00;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({psel, penable, pwrite, paddr, pwdata, coef_tready, busy, done, error}), 64'd0);
    rst_n = 1'b1;

    // Nominal load: ramp data, continuous source, first poll ready.
    setup_run(0, 0, 1'b1);
    kick(s0); wait_end(s0, 0); check_run(s0, 0, 0);

    // Source stalls with a 1,0,0 valid pattern.
    f = $urandom_range(0, 2);
    setup_run(1, f, 1'b0);
    kick(s0); wait_end(s0, 0); check_run(s0, f, 1);

    // Slow arm: three unready reads, then ready.
    setup_run(0, 3, 1'b0);
    kick(s0); wait_end(s0, 0); check_run(s0, 3, 0);

    // Poll timeout: status never becomes ready.
    setup_run(0, 1000, 1'b0);
    kick(s0); wait_end(s0, 0); check_run(s0, 1000, 0);

    // Start pulse during LOAD is ignored.
    f = $urandom_range(0, 3);
    setup_run(2, f, 1'b0);
    kick(s0); wait_end(s0, $urandom_range(5, 14)); check_run(s0, f, 2);

    // Asynchronous reset in the access cycle of word 3, then a clean rerun.
    setup_run(0, 0, 1'b0);
    kick(s0);
    t = 0;
    while (!(psel && penable && pwrite && paddr == AW'(12)) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("word3_access_reached", 64'(t < 100), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 64'({psel, penable, pwrite, paddr, pwdata, coef_tready, busy, done, error}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    setup_run(0, 1, 1'b0);
    kick(s0); wait_end(s0, 0); check_run(s0, 1, 0);

    // Randomized mixes of source behaviour and poll outcome.
    for (int r = 0; r < 3; r++) begin
      int m;
      m = $urandom_range(0, 2);
      f = $urandom_range(0, 5);
      setup_run(m, f, 1'b0);
      kick(s0); wait_end(s0, 0); check_run(s0, f, m);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/wfunc_loader.md
# wfunc_loader

APB master that programs and arms the `window_func` block. On a `start` pulse it:
- soft-resets the window FSM,
- streams FFT_SIZE window coefficients from an AXI-Stream-like source into window memory,
- issues "CHANGE STATE",
- polls the status register until the window block reports WAIT or BUSY.

It sits between the coefficient source (DMA/ROM reader) and the `window_func` APB port, and replaces software-driven window loading.

## Interface
Parameters:
- FFT_SIZE, 8192: window length (power of 2); must match `window_func`.
- APB_AW, $clog2(FFT_SIZE-1)+3: APB address width; must match `window_func`.
- POLL_GAP, 4: idle cycles between consecutive status reads (≥0).
- MAX_POLLS, 16: failing status reads before giving up (≥1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle load request; ignored while busy=1.
- busy  out  1  high from the cycle after an accepted start until done/error.
- done  out  1  one-cycle pulse: window armed successfully.
- error  out  1  one-cycle pulse: poll limit exhausted.
- coef_tvalid  in  1  coefficient valid.
- coef_tready  out  1  coefficient accept.
- coef_tdata  in  32  coefficient: [31:16] imaginary, [15:0] real; delivered in address order 0..FFT_SIZE-1.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB write.
- paddr  out  APB_AW  APB address.
- pwdata  out  32  APB write data.
- prdata  in  32  APB read data, combinational from the slave.

## Operation
- No pready: every APB transfer is exactly one setup cycle (psel=1, penable=0) followed by one access cycle (psel=1, penable=1).
- A setup cycle may immediately follow an access cycle.
- All APB outputs are registered.

State machine:
- **IDLE**
  - All APB outputs 0, busy=0.
  - start=1 → RST.
- **RST**
  - One write: paddr=FFT_SIZE*4, pwdata=32'h1 (FSM reset).
  - After the access cycle → LOAD.
- **LOAD**
  - coef_tready=1 whenever the next cycle can be a setup cycle, i.e. the current cycle is not a setup cycle.
  - On handshake, the next cycle is setup with paddr=cnt*4, pwdata=coef_tdata, pwrite=1.
  - cnt is $clog2(FFT_SIZE) bits, cleared on entry, incremented per handshake.
  - With coef_tvalid=0, the bus idles (psel=0).
  - After the access cycle of word FFT_SIZE-1 → ARM.
  - coef_tready=0 in all other states; surplus words are never consumed.
- **ARM**
  - One write: paddr=FFT_SIZE*4, pwdata=32'h100 (CHANGE STATE).
  - After the access cycle → POLL.
- **POLL**
  - Read: paddr=(FFT_SIZE+1)*4, pwrite=0.
  - prdata[9:8] is sampled in the access cycle.
  - 2'b01 (WAIT) or 2'b10 (BUSY) → done pulse next cycle, then IDLE.
  - Otherwise increment poll_cnt.
    - If poll_cnt reaches MAX_POLLS → error pulse next cycle, then IDLE.
    - Else wait POLL_GAP idle cycles (psel=0), then read again.
- busy=1 in RST, LOAD, ARM, POLL, and in the done/error cycle.
- start while busy is ignored; no queuing.
- Reset (asynchronous, any time, including mid-transfer):
  - psel, penable, pwrite, paddr, pwdata, coef_tready, busy, done, error all 0.
  - State IDLE; counters cleared.
  - A half-finished APB transfer is abandoned; recovery is the next start, whose RST write re-idles the slave.

## Timing
- start sampled high at cycle 0:
  - RST setup at cycle 1, access at cycle 2.
  - LOAD entered at cycle 3 with coef_tready=1.
- With coef_tvalid held 1:
  - Word k: setup at cycle 4+2k, access at cycle 5+2k.
  - coef_tready is high in access cycles and low in setup cycles.
- ARM: setup at 2N+4, access at 2N+5 (N=FFT_SIZE).
- First poll: setup at 2N+6, access at 2N+7.
- done at 2N+8 if the first poll succeeds. The slave status reaches WAIT at 2N+6, so the first poll succeeds against a conforming `window_func`.
- Each failed poll adds 2+POLL_GAP cycles.
- Coefficient stalls add cycles one-for-one; partial transfers are never issued.

## Test plan
- **Nominal load.** FFT_SIZE=8, coef_tdata=k*32'h00010001 continuously valid, start at cycle 0.
  - Writes to 0x00..0x1C with matching data.
  - Writes 0x1 then 0x100 to 0x20.
  - One read of 0x24; done=1 exactly at cycle 24; busy low at cycle 25.
- **Source stalls.** coef_tvalid toggles 1,0,0,1…
  - No APB transfer while starved.
  - Each address written exactly once, in order.
  - coef_tready never high in a setup cycle.
- **Slow arm.** prdata[9:8]=00 for 3 reads then 01, POLL_GAP=4.
  - 4 reads separated by 4 idle cycles; done after the 4th access; error=0.
- **Poll timeout.** prdata[9:8] held 00, MAX_POLLS=16.
  - Exactly 16 reads; error pulse once; done=0; return to IDLE.
- **Start while busy.** Pulse start during LOAD.
  - No restart; counter unaffected; a single done.
- **Reset mid-operation.** rst_n low during the access cycle of word 3.
  - All outputs 0 asynchronously.
  - A new start performs the full sequence from the RST write and address 0.
